// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: state encoding,
// round-robin pick function and the default watchdog limit.
package mult_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int wdog_default(input int width);
    return 4 * width + 8;
  endfunction

  // First asserted request scanning upward from ptr+1, wrapping at num_req.
  function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                         input logic [MAX_REQ-1:0] req,
                                         input int num_req);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req) begin
        idx = (int'(ptr) + k) % num_req;
        if (!found && req[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier signals of the arbiter; master is the arbiter side.
// The timeout pair exists only when MULT_ARB_WATCHDOG_EN is defined.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req, req_t;
  logic [NUM_REQ*WIDTH-1:0] a_in, b_in;
  logic [NUM_REQ-1:0]       a_in_t, b_in_t;
  logic [NUM_REQ-1:0]       gnt, done;
  logic                     gnt_t, done_t;
  logic [2*WIDTH-1:0]       product_out;
  logic                     product_t;
  logic                     busy;
  logic                     mult_start, mult_start_t;
  logic [WIDTH-1:0]         mult_a, mult_b;
  logic                     mult_a_t, mult_b_t;
  logic                     mult_done, mult_done_t;
  logic [2*WIDTH-1:0]       mult_product;
  logic                     mult_product_t;
`ifdef MULT_ARB_WATCHDOG_EN
  logic                     timeout, timeout_t;
`endif

  modport master (
`ifdef MULT_ARB_WATCHDOG_EN
    output timeout, output timeout_t,
`endif
    input  req, input req_t, input a_in, input a_in_t, input b_in, input b_in_t,
    output gnt, output gnt_t, output done, output done_t,
    output product_out, output product_t, output busy,
    output mult_start, output mult_start_t,
    output mult_a, output mult_b, output mult_a_t, output mult_b_t,
    input  mult_done, input mult_done_t, input mult_product, input mult_product_t
  );

  modport slave (
`ifdef MULT_ARB_WATCHDOG_EN
    input  timeout, input timeout_t,
`endif
    output req, output req_t, output a_in, output a_in_t, output b_in, output b_in_t,
    input  gnt, input gnt_t, input done, input done_t,
    input  product_out, input product_t, input busy,
    input  mult_start, input mult_start_t,
    input  mult_a, input mult_b, input mult_a_t, input mult_b_t,
    output mult_done, output mult_done_t, output mult_product, output mult_product_t
  );
endinterface

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin pick; the selection taint depends on every request.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_t,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any_req,
  output logic               pick_t
);
  assign any_req = |req;
  assign pick_t  = |req_t;
  assign pick    = IDX_W'(next_rr(3'(ptr), MAX_REQ'(req), NUM_REQ));
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one sequential multiplier among NUM_REQ requesters,
// with taint tracking. Optional BUSY watchdog enabled by defining MULT_ARB_WATCHDOG_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4
`ifdef MULT_ARB_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = wdog_default(WIDTH)
`endif
) (
  input logic                  clk,
  input logic                  rst,
  mult_share_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, ptr, pick;
  logic               any_req, pick_t, arb_t;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               a_t_q, b_t_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               prod_t_q, done_t_q;
  logic               wdog_hit;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (bus.req),
    .req_t   (bus.req_t),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req),
    .pick_t  (pick_t)
  );

`ifdef MULT_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] wdog_cnt;
  logic             timeout_q, timeout_t_q;

  // The hit fires on the edge where the count would reach WDOG_CYCLES.
  assign wdog_hit = (state == ST_BUSY) && !bus.mult_done &&
                    (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt    <= '0;
      timeout_q   <= 1'b0;
      timeout_t_q <= 1'b0;
    end else begin
      if (state == ST_START) wdog_cnt <= '0;
      else if (state == ST_BUSY) wdog_cnt <= wdog_cnt + 1'b1;
      if (state == ST_BUSY) begin
        timeout_q   <= wdog_hit;
        timeout_t_q <= arb_t | bus.mult_done_t;
      end
    end
  end

  assign bus.timeout   = timeout_q && (state == ST_DONE);
  assign bus.timeout_t = timeout_t_q;
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.gnt        = '0;
    bus.done       = '0;
    bus.mult_start = 1'b0;
    unique case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_LOAD;
      ST_LOAD: begin
        bus.gnt[owner] = 1'b1;
        state_nxt      = ST_START;
      end
      ST_START: begin
        bus.mult_start = 1'b1;
        state_nxt      = ST_BUSY;
      end
      ST_BUSY:  if (bus.mult_done || wdog_hit) state_nxt = ST_DONE;
      ST_DONE: begin
        bus.done[owner] = 1'b1;
        state_nxt       = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Product and its taints land on the BUSY exit edge so they are valid during the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= '0;
      ptr      <= IDX_W'(NUM_REQ - 1);
      arb_t    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      a_t_q    <= 1'b0;
      b_t_q    <= 1'b0;
      prod_q   <= '0;
      prod_t_q <= 1'b0;
      done_t_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (any_req) begin
          owner <= pick;
          arb_t <= pick_t;
        end
        ST_LOAD: begin
          a_q   <= bus.a_in[owner*WIDTH +: WIDTH];
          b_q   <= bus.b_in[owner*WIDTH +: WIDTH];
          a_t_q <= bus.a_in_t[owner];
          b_t_q <= bus.b_in_t[owner];
          ptr   <= owner;
        end
        ST_BUSY: if (bus.mult_done || wdog_hit) begin
          prod_q   <= bus.mult_done ? bus.mult_product : '0;
          prod_t_q <= bus.mult_product_t | arb_t | bus.mult_done_t | a_t_q | b_t_q;
          done_t_q <= arb_t | bus.mult_done_t;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt_t        = arb_t;
  assign bus.mult_start_t = arb_t;
  assign bus.done_t       = done_t_q;
  assign bus.product_out  = prod_q;
  assign bus.product_t    = prod_t_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.mult_a       = a_q;
  assign bus.mult_b       = b_q;
  assign bus.mult_a_t     = a_t_q;
  assign bus.mult_b_t     = b_t_q;

endmodule
